// File: rtl/rmt_input_arbiter.sv
// Packet-atomic 2:1 AXI-Stream arbiter: config (port 0) first, data (port 1) after a bounded config burst.
// Latency: zero-cycle passthrough within a packet; one idle bubble cycle between packets.
// Backpressure: m_axis_tready goes straight to the granted port; tready never depends on any tvalid.
module rmt_input_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MAX_CFG_BURST        = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                              s0_axis_tvalid,
  input  logic                              s0_axis_tlast,
  output logic                              s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                              s1_axis_tvalid,
  input  logic                              s1_axis_tlast,
  output logic                              s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              data_freeze,
  output logic                              cfg_active,
  output logic [CNT_WIDTH-1:0]              cfg_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              data_pkt_cnt
);

  localparam int STREAK_W = (MAX_CFG_BURST > 0) ? $clog2(MAX_CFG_BURST + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CFG_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [STREAK_W-1:0]   cfg_streak_q, cfg_streak_d;
  logic [CNT_WIDTH-1:0]  cfg_cnt_q, cfg_cnt_d;
  logic [CNT_WIDTH-1:0]  data_cnt_q, data_cnt_d;

  logic grant0, grant1;
  logic s0_last_xfer, s1_last_xfer;
  logic burst_ok;
  logic data_wants;

  // Grants are masked by reset so the handshakes drop in the same cycle reset rises.
  assign grant0 = (state_q == GRANT0) && !areset;
  assign grant1 = (state_q == GRANT1) && !areset;

  assign s0_axis_tready = grant0 && m_axis_tready;
  assign s1_axis_tready = grant1 && m_axis_tready;

  assign m_axis_tvalid = (grant0 && s0_axis_tvalid) || (grant1 && s1_axis_tvalid);
  assign m_axis_tdata  = grant1 ? s1_axis_tdata : s0_axis_tdata;
  assign m_axis_tkeep  = grant1 ? s1_axis_tkeep : s0_axis_tkeep;
  assign m_axis_tuser  = grant1 ? s1_axis_tuser : s0_axis_tuser;
  assign m_axis_tlast  = grant1 ? s1_axis_tlast : s0_axis_tlast;

  assign cfg_active   = (state_q == GRANT0);
  assign cfg_pkt_cnt  = cfg_cnt_q;
  assign data_pkt_cnt = data_cnt_q;

  assign s0_last_xfer = grant0 && s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
  assign s1_last_xfer = grant1 && s1_axis_tvalid && m_axis_tready && s1_axis_tlast;

  // Data is only "waiting" when it could actually be granted (not frozen).
  assign data_wants = s1_axis_tvalid && !data_freeze;
  assign burst_ok   = (MAX_CFG_BURST == 0) || (cfg_streak_q < STREAK_MAX);

  // Next-state, streak and packet counter logic.
  always_comb begin
    state_d      = state_q;
    cfg_streak_d = cfg_streak_q;
    cfg_cnt_d    = cfg_cnt_q;
    data_cnt_d   = data_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && (burst_ok || !data_wants)) begin
          state_d = GRANT0;
          if (data_wants && (MAX_CFG_BURST != 0)) begin
            cfg_streak_d = cfg_streak_q + STREAK_W'(1);
          end else begin
            cfg_streak_d = '0;
          end
        end else if (data_wants) begin
          state_d      = GRANT1;
          cfg_streak_d = '0;
        end
      end
      GRANT0: begin
        if (s0_last_xfer) begin
          state_d   = IDLE;
          cfg_cnt_d = cfg_cnt_q + CNT_WIDTH'(1);
        end
      end
      GRANT1: begin
        if (s1_last_xfer) begin
          state_d    = IDLE;
          data_cnt_d = data_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, streak and counter registers with immediate reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      cfg_streak_q <= '0;
      cfg_cnt_q    <= '0;
      data_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_streak_q <= cfg_streak_d;
      cfg_cnt_q    <= cfg_cnt_d;
      data_cnt_q   <= data_cnt_d;
    end
  end

endmodule

// File: tb/tb_rmt_input_arbiter.sv
// Bench for rmt_input_arbiter: table of single-decision vectors plus multi-cycle stream scenarios.
// Sources are driven from beat queues; every output beat is scored against the source beat it came from.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_rmt_input_arbiter;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    bit s0v, s1v, frz, mrdy;
    bit e_s0r, e_s1r, e_mv, e_act;
    int e_cfg, e_dat;
  } vec_t;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0, m_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep = '0, s1_axis_tkeep = '0, m_axis_tkeep;
  logic [UW-1:0] s0_axis_tuser = '0, s1_axis_tuser = '0, m_axis_tuser;
  logic          s0_axis_tvalid = 1'b0, s0_axis_tlast = 1'b0, s0_axis_tready;
  logic          s1_axis_tvalid = 1'b0, s1_axis_tlast = 1'b0, s1_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          data_freeze = 1'b0;
  logic          cfg_active;
  logic [31:0]   cfg_pkt_cnt, data_pkt_cnt;

  // Narrow-counter twin, used only to observe counter wrap.
  logic          w_s0_rdy, w_s1_rdy, w_m_vld, w_m_last, w_act;
  logic [DW-1:0] w_m_data;
  logic [KW-1:0] w_m_keep;
  logic [UW-1:0] w_m_user;
  logic [1:0]    w_cfg_cnt, w_dat_cnt;

  rmt_input_arbiter u_dut (
    .clk(clk), .areset(areset),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .data_freeze(data_freeze), .cfg_active(cfg_active),
    .cfg_pkt_cnt(cfg_pkt_cnt), .data_pkt_cnt(data_pkt_cnt)
  );

  rmt_input_arbiter #(.CNT_WIDTH(2)) u_dut_wrap (
    .clk(clk), .areset(areset),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(w_s0_rdy),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(w_s1_rdy),
    .m_axis_tdata(w_m_data), .m_axis_tkeep(w_m_keep), .m_axis_tuser(w_m_user),
    .m_axis_tvalid(w_m_vld), .m_axis_tlast(w_m_last), .m_axis_tready(m_axis_tready),
    .data_freeze(data_freeze), .cfg_active(w_act),
    .cfg_pkt_cnt(w_cfg_cnt), .data_pkt_cnt(w_dat_cnt)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  beat_t  q0[$];
  beat_t  q1[$];
  int     glog[$];
  int     x0_cyc[$];
  int     x1_cyc[$];
  int     n_xfer, act_cycles, s1r_cycles;
  bit     out_first, hold_vld;
  logic [DW-1:0] hold_dat;
  logic [3:0]    rdy_pat = 4'b1111;
  vec_t   vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_beat(input beat_t act, input beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL beat: got user=%0h last=%0b data[31:0]=%0h, wanted user=%0h last=%0b data[31:0]=%0h",
               act.user, act.last, act.data[31:0], exp.user, exp.last, exp.data[31:0]);
    end
  endtask

  task automatic do_reset();
    s0_axis_tvalid = 1'b0;
    s1_axis_tvalid = 1'b0;
    areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
  endtask

  task automatic push_pkt(input int port, input int nbeats, input int tag);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {16{32'(tag * 256 + i)}};
      b.keep = (i == nbeats - 1 && nbeats > 1) ? 64'h00000000000fffff : '1;
      b.user = {4{32'(port * 1000 + tag)}};
      b.last = (i == nbeats - 1);
      if (port == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic clear_logs();
    glog.delete(); x0_cyc.delete(); x1_cyc.delete();
    n_xfer = 0; act_cycles = 0; s1r_cycles = 0;
    out_first = 1'b1; hold_vld = 1'b0;
  endtask

  task automatic drive(input bit en0);
    if (en0 && q0.size() > 0) begin
      {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast} = q0[0];
      s0_axis_tvalid = 1'b1;
    end else begin
      s0_axis_tvalid = 1'b0;
    end
    if (q1.size() > 0) begin
      {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast} = q1[0];
      s1_axis_tvalid = 1'b1;
    end else begin
      s1_axis_tvalid = 1'b0;
    end
  endtask

  // Runs the queued sources until the awaited queues drain; cycle numbers restart at 0.
  task automatic run(input int budget, input bit wait0, input bit wait1, input int s0_start);
    int  cyc;
    bit  x0, x1, xm;
    cyc = 0;
    m_axis_tready = rdy_pat[0];
    while ((wait0 && q0.size() > 0) || (wait1 && q1.size() > 0)) begin
      if (cyc >= budget) begin
        n_cmp++; n_err++;
        $display("FAIL run_timeout: got %0d cycles without draining, wanted at most %0d", cyc, budget);
        break;
      end
      drive(cyc >= s0_start);
      @(negedge clk);
      x0 = s0_axis_tvalid && s0_axis_tready;
      x1 = s1_axis_tvalid && s1_axis_tready;
      xm = m_axis_tvalid && m_axis_tready;
      if (hold_vld) check("stall_data_stable", m_axis_tdata[63:0] ^ hold_dat[63:0] | 64'(m_axis_tdata != hold_dat), 64'd0);
      hold_vld = m_axis_tvalid && !m_axis_tready;
      hold_dat = m_axis_tdata;
      act_cycles += int'(cfg_active);
      s1r_cycles += int'(s1_axis_tready);
      if (xm || x0 || x1) check("xfer_pairing", {62'd0, x1, x0}, xm ? (s0_axis_tready ? 64'd1 : 64'd2) : 64'd0);
      if (xm && (x0 ^ x1)) begin
        check_beat({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, x1 ? q1[0] : q0[0]);
        n_xfer++;
        if (out_first) glog.push_back(int'(x1));
        out_first = m_axis_tlast;
        if (x0) x0_cyc.push_back(cyc);
        if (x1) x1_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (x0) void'(q0.pop_front());
      if (x1) void'(q1.pop_front());
      cyc++;
      m_axis_tready = rdy_pat[cyc % 4];
    end
    drive(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          s0v s1v frz rdy | s0r s1r mv act | cfg dat
    vt[0] = '{0, 0, 0, 1,  0, 0, 0, 0,  0, 0};
    vt[1] = '{1, 0, 0, 1,  1, 0, 1, 1,  1, 0};
    vt[2] = '{0, 1, 0, 1,  0, 1, 1, 0,  0, 1};
    vt[3] = '{1, 1, 0, 1,  1, 0, 1, 1,  1, 0};
    vt[4] = '{0, 1, 1, 1,  0, 0, 0, 0,  0, 0};
    vt[5] = '{1, 1, 1, 1,  1, 0, 1, 1,  1, 0};
    vt[6] = '{1, 0, 1, 0,  0, 0, 1, 1,  0, 0};
    vt[7] = '{0, 1, 0, 0,  0, 0, 1, 0,  0, 0};
    vt[8] = '{1, 0, 1, 1,  1, 0, 1, 1,  1, 0};

    // Values while reset is held.
    @(negedge clk);
    check("rst_s0_tready", s0_axis_tready, 0);
    check("rst_s1_tready", s1_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_cfg_active", cfg_active, 0);
    check("rst_cfg_cnt", cfg_pkt_cnt, 0);
    check("rst_data_cnt", data_pkt_cnt, 0);

    // Single-decision vectors, each from a fresh reset with single-beat packets.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      s0_axis_tdata = {16{32'ha5a5_0000}}; s0_axis_tlast = 1'b1; s0_axis_tvalid = vt[i].s0v;
      s1_axis_tdata = {16{32'h5a5a_1111}}; s1_axis_tlast = 1'b1; s1_axis_tvalid = vt[i].s1v;
      data_freeze = vt[i].frz;
      m_axis_tready = vt[i].mrdy;
      @(negedge clk);
      check($sformatf("vec%0d_idle_s0rdy", i), s0_axis_tready, 0);
      check($sformatf("vec%0d_idle_s1rdy", i), s1_axis_tready, 0);
      check($sformatf("vec%0d_idle_mvld", i), m_axis_tvalid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("vec%0d_s0rdy", i), s0_axis_tready, vt[i].e_s0r);
      check($sformatf("vec%0d_s1rdy", i), s1_axis_tready, vt[i].e_s1r);
      check($sformatf("vec%0d_mvld", i), m_axis_tvalid, vt[i].e_mv);
      check($sformatf("vec%0d_cfg_active", i), cfg_active, vt[i].e_act);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("vec%0d_cfg_cnt", i), cfg_pkt_cnt, 64'(vt[i].e_cfg));
      check($sformatf("vec%0d_data_cnt", i), data_pkt_cnt, 64'(vt[i].e_dat));
      s0_axis_tvalid = 1'b0;
      s1_axis_tvalid = 1'b0;
    end
    data_freeze = 1'b0;
    m_axis_tready = 1'b1;

    // Config-only run: four two-beat packets.
    do_reset();
    clear_logs();
    for (int p = 0; p < 4; p++) push_pkt(0, 2, p);
    run(40, 1, 0, 0);
    check("cfgonly_xfers", n_xfer, 8);
    check("cfgonly_cfg_cnt", cfg_pkt_cnt, 4);
    check("cfgonly_data_cnt", data_pkt_cnt, 0);
    check("cfgonly_active_cycles", act_cycles, 8);

    // Starvation bound: both ports continuously offer single-beat packets.
    do_reset();
    clear_logs();
    for (int p = 0; p < 20; p++) push_pkt(0, 1, 100 + p);
    for (int p = 0; p < 5; p++) push_pkt(1, 1, 200 + p);
    run(120, 1, 1, 0);
    check("starve_pkts", glog.size(), 25);
    for (int i = 0; i < glog.size(); i++)
      check($sformatf("starve_grant%0d", i), glog[i], (i % 5 == 4) ? 1 : 0);
    check("starve_cfg_cnt", cfg_pkt_cnt, 20);
    check("starve_data_cnt", data_pkt_cnt, 5);
    check("wrap_cfg_cnt", w_cfg_cnt, 0);
    check("wrap_data_cnt", w_dat_cnt, 1);

    // Freeze: data held off while config flows, then released.
    do_reset();
    clear_logs();
    data_freeze = 1'b1;
    push_pkt(1, 3, 300);
    push_pkt(0, 2, 301);
    push_pkt(0, 2, 302);
    run(40, 1, 0, 0);
    check("freeze_xfers", n_xfer, 4);
    check("freeze_s1_rdy_cycles", s1r_cycles, 0);
    check("freeze_s1_left", q1.size(), 3);
    check("freeze_cfg_cnt", cfg_pkt_cnt, 2);
    check("freeze_data_cnt", data_pkt_cnt, 0);
    data_freeze = 1'b0;
    clear_logs();
    run(40, 0, 1, 0);
    check("unfreeze_xfers", n_xfer, 3);
    check("unfreeze_data_cnt", data_pkt_cnt, 1);

    // Atomicity: config appears on beat 2 of a data packet.
    do_reset();
    clear_logs();
    push_pkt(1, 3, 400);
    push_pkt(0, 1, 401);
    run(40, 1, 1, 2);
    check("atom_s1_beats", x1_cyc.size(), 3);
    check("atom_s0_beats", x0_cyc.size(), 1);
    if (x1_cyc.size() == 3 && x0_cyc.size() == 1) begin
      check("atom_s1_first_cyc", x1_cyc[0], 1);
      check("atom_s1_last_cyc", x1_cyc[2], 3);
      check("atom_s0_cyc", x0_cyc[0], 5);
    end

    // Back-pressure: ready pattern 1,0,0,1 over a three-beat packet (no reset: counters carry on).
    clear_logs();
    rdy_pat = 4'b1001;
    push_pkt(1, 3, 500);
    run(40, 0, 1, 0);
    rdy_pat = 4'b1111;
    m_axis_tready = 1'b1;
    check("bp_xfers", n_xfer, 3);
    check("bp_data_cnt", data_pkt_cnt, 2);
    check("bp_cfg_cnt", cfg_pkt_cnt, 1);

    // Reset on beat 2 of a config packet.
    s0_axis_tdata = {16{32'hc0f1_0001}}; s0_axis_tlast = 1'b0; s0_axis_tvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_beat1_rdy", s0_axis_tready, 1);
    @(posedge clk); #1;
    s0_axis_tdata = {16{32'hc0f1_0002}};
    #2 areset = 1'b1;
    #1;
    check("rstmid_s0_tready", s0_axis_tready, 0);
    check("rstmid_s1_tready", s1_axis_tready, 0);
    check("rstmid_m_tvalid", m_axis_tvalid, 0);
    check("rstmid_cfg_active", cfg_active, 0);
    check("rstmid_cfg_cnt", cfg_pkt_cnt, 0);
    check("rstmid_data_cnt", data_pkt_cnt, 0);
    s0_axis_tvalid = 1'b0;
    @(posedge clk); #1 areset = 1'b0;
    clear_logs();
    push_pkt(1, 2, 600);
    run(40, 0, 1, 0);
    check("postrst_xfers", n_xfer, 2);
    check("postrst_pkts", glog.size(), 1);
    if (glog.size() == 1) check("postrst_port", glog[0], 1);
    check("postrst_data_cnt", data_pkt_cnt, 1);
    check("postrst_cfg_cnt", cfg_pkt_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
